// File: rtl/instr_fetch_dispatch.sv
// Issue side of the execution-FSM protocol: fetches 16-bit words at PC, presents them on ir_out,
// applies pc_inc pulses, waits for done and retires, driving a NOP word between instructions.
module instr_fetch_dispatch #(
  parameter int unsigned ADDR_W       = 8,
  parameter logic [15:0] OPC_MASK     = 16'h00FF,
  parameter logic [3:0]  HALT_OPC     = 4'hF,
  parameter logic [3:0]  NOP_OPC      = 4'hE,
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       ir_out,
  output logic              ir_valid,
  input  logic              pc_inc_req,
  input  logic              exec_done,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired_cnt,
  output logic              halted,
  output logic              illegal_op,
  output logic              timeout_err
);

  localparam int unsigned WD_W    = 8;
  localparam logic [15:0] NOP_WORD = {NOP_OPC, 12'h000};
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_RETIRE, S_HALT, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [15:0]       retired_q, retired_d;
  logic [15:0]       ir_out_q, ir_out_d;
  logic              ir_valid_q, ir_valid_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [3:0]        opcode;

  assign opcode = ir_q[15:12];

  // Next-state and next-output logic; outputs are derived from the next state so that
  // each registered output lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wd_d       = wd_q;
    retired_d  = retired_q;
    mem_addr_d = mem_addr_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == HALT_OPC) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!OPC_MASK[opcode]) begin
          state_d   = S_ERROR;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
          wd_d    = '0;
        end
      end
      S_EXEC: begin
        if (pc_inc_req) pc_d = pc_q + ADDR_W'(1);
        // done takes priority over a watchdog expiry in the same cycle
        if (exec_done) begin
          state_d = S_RETIRE;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RETIRE: begin
        if (pc_inc_req) pc_d = pc_q + ADDR_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT, S_ERROR: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mem_rd_d   = (state_d == S_FETCH);
    if (mem_rd_d) mem_addr_d = pc_d;
    ir_valid_d = (state_d == S_EXEC);
    ir_out_d   = ir_valid_d ? ir_d : NOP_WORD;
    if (state_q == S_EXEC && state_d == S_RETIRE) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= NOP_WORD;
      wd_q       <= '0;
      retired_q  <= '0;
      ir_out_q   <= NOP_WORD;
      ir_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wd_q       <= wd_d;
      retired_q  <= retired_d;
      ir_out_q   <= ir_out_d;
      ir_valid_q <= ir_valid_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign ir_out      = ir_out_q;
  assign ir_valid    = ir_valid_q;
  assign pc          = pc_q;
  assign retired_cnt = retired_q;
  assign halted      = halted_q;
  assign illegal_op  = illegal_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Bench for instr_fetch_dispatch: memory model, stub execution FSM and an issue scoreboard.
module tb_instr_fetch_dispatch;

  localparam int unsigned ADDR_W = 8;
  localparam logic [15:0] NOP_WORD = 16'hE000;

  logic              clk;
  logic              rst;
  logic              run;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_rvalid;
  logic [15:0]       ir_out;
  logic              ir_valid;
  logic              pc_inc_req;
  logic              exec_done;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       retired_cnt;
  logic              halted;
  logic              illegal_op;
  logic              timeout_err;

  instr_fetch_dispatch #(
    .ADDR_W(ADDR_W), .OPC_MASK(16'h00FF), .HALT_OPC(4'hF), .NOP_OPC(4'hE), .DONE_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .ir_out(ir_out), .ir_valid(ir_valid), .pc_inc_req(pc_inc_req), .exec_done(exec_done),
    .pc(pc), .retired_cnt(retired_cnt), .halted(halted), .illegal_op(illegal_op),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] word;
    int          len;
  } exp_t;

  logic [15:0] mem [256];
  exp_t        exp_q[$];
  int          done_at;
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Program memory: data valid exactly one cycle after the read strobe
  initial begin
    logic       pend;
    logic [7:0] paddr;
    pend = 1'b0;
    paddr = '0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = pend;
      mem_rdata  = pend ? mem[paddr] : 16'h0000;
      pend  = mem_rd;
      paddr = mem_addr;
    end
  end

  // Stub execution FSM: pc_inc in EXEC cycle 1, done in cycle done_at (0 = never)
  initial begin
    int cyc;
    cyc = 0;
    pc_inc_req = 1'b0;
    exec_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ir_valid) cyc++;
      else cyc = 0;
      pc_inc_req = ir_valid && (cyc == 1);
      exec_done  = ir_valid && (done_at != 0) && (cyc == done_at);
    end
  end

  // Monitor: each issued word is popped and compared, its EXEC length checked on retire
  initial begin
    bit   in_exec;
    bit   has_exp;
    int   len;
    exp_t cur;
    in_exec = 0;
    has_exp = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_exec = 0;
      end else if (ir_valid && !in_exec) begin
        in_exec = 1;
        len = 1;
        if (exp_q.size() == 0) begin
          has_exp = 0;
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got ir_out %0h with no instruction expected", ir_out);
        end else begin
          has_exp = 1;
          cur = exp_q.pop_front();
          check("ir_word", 32'(ir_out), 32'(cur.word));
        end
      end else if (ir_valid) begin
        len++;
      end else if (in_exec) begin
        in_exec = 0;
        if (has_exp) check("exec_len", 32'(len), 32'(cur.len));
        check("nop_after_exec", 32'(ir_out), 32'(NOP_WORD));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_retired", 32'(retired_cnt), 32'h0);
    check("rst_ir_out", 32'(ir_out), 32'(NOP_WORD));
    check("rst_flags", {26'h0, ir_valid, mem_rd, halted, illegal_op, timeout_err, 1'b0}, 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    rst = 1'b0;
  endtask

  task automatic wait_until(input int which, input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      case (which)
        0: hit = halted;
        1: hit = illegal_op;
        2: hit = timeout_err;
        3: hit = ir_valid;
        default: hit = mem_rd;
      endcase
      if (hit) break;
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_%s: got no event expected event within 300 cycles", name);
    end
  endtask

  initial begin
    int n;
    bit saw;
    n_tests = 0;
    n_fail = 0;
    done_at = 3;
    rst = 1'b1;
    run = 1'b0;

    // 1: single MOVI, done in EXEC cycle 3
    do_reset();
    mem[0] = 16'h7085;
    done_at = 3;
    exp_q.push_back('{16'h7085, 3});
    run = 1'b1;
    wait_until(0, "halt1");
    check("t1_pc", 32'(pc), 32'h1);
    check("t1_retired", 32'(retired_cnt), 32'h1);
    check("t1_ir_out", 32'(ir_out), 32'(NOP_WORD));

    // 2: back-to-back identical words, then halt
    do_reset();
    mem[0] = 16'h7085;
    mem[1] = 16'h7085;
    exp_q.push_back('{16'h7085, 3});
    exp_q.push_back('{16'h7085, 3});
    run = 1'b1;
    wait_until(0, "halt2");
    check("t2_pc", 32'(pc), 32'h2);
    check("t2_retired", 32'(retired_cnt), 32'h2);

    // 3: halted with run=1 must not fetch
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd) saw = 1;
    end
    check("t3_no_fetch", 32'(saw), 32'h0);
    check("t3_halted", 32'(halted), 32'h1);
    check("t3_no_illegal", 32'(illegal_op), 32'h0);

    // 4: illegal opcode 0xA
    do_reset();
    mem[0] = 16'hA000;
    run = 1'b1;
    wait_until(1, "illegal");
    repeat (3) @(negedge clk);
    check("t4_illegal", 32'(illegal_op), 32'h1);
    check("t4_halted", 32'(halted), 32'h0);
    check("t4_retired", 32'(retired_cnt), 32'h0);
    check("t4_ir_out", 32'(ir_out), 32'(NOP_WORD));

    // 5a: done never arrives -> timeout 15 cycles after ir_valid rises
    do_reset();
    mem[0] = 16'h7085;
    done_at = 0;
    exp_q.push_back('{16'h7085, 15});
    run = 1'b1;
    wait_until(3, "issue5a");
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
    end
    check("t5a_timeout_latency", 32'(n), 32'd15);
    check("t5a_timeout", 32'(timeout_err), 32'h1);
    check("t5a_retired", 32'(retired_cnt), 32'h0);
    check("t5a_pc", 32'(pc), 32'h1);

    // 5b: done in the final watchdog cycle wins
    do_reset();
    mem[0] = 16'h7085;
    done_at = 15;
    exp_q.push_back('{16'h7085, 15});
    run = 1'b1;
    wait_until(0, "halt5b");
    check("t5b_no_timeout", 32'(timeout_err), 32'h0);
    check("t5b_retired", 32'(retired_cnt), 32'h1);

    // 6: reset mid-EXEC, then refetch from address 0
    do_reset();
    mem[0] = 16'h7085;
    done_at = 0;
    exp_q.push_back('{16'h7085, 0});
    run = 1'b1;
    wait_until(3, "issue6");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_async_pc", 32'(pc), 32'h0);
    check("t6_async_ir", 32'(ir_out), 32'(NOP_WORD));
    check("t6_async_valid", 32'(ir_valid), 32'h0);
    check("t6_async_retired", 32'(retired_cnt), 32'h0);
    done_at = 3;
    exp_q.push_back('{16'h7085, 3});
    @(negedge clk);
    rst = 1'b0;
    wait_until(4, "refetch");
    check("t6_refetch_addr", 32'(mem_addr), 32'h0);
    wait_until(0, "halt6");
    check("t6_pc", 32'(pc), 32'h1);
    check("t6_retired", 32'(retired_cnt), 32'h1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
